// File: rtl/dift_tag_check_unit.sv
// DIFT tag check unit: enforcement end of the tag pipeline, sitting beside the
// ALU in EX. It flags tainted data reaching a sensitive use point. It then either
// raises an exception request, which it holds until the controller acks it, or
// only counts the violation when the unit is in audit mode.
module dift_tag_check_unit #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       tccr_i,
  input  logic             check_valid_i,
  input  logic [2:0]       chk_class_i,
  input  logic [31:0]      pc_i,
  input  logic [TAG_W-1:0] operand_a_tag_i,
  input  logic [TAG_W-1:0] operand_b_tag_i,
  input  logic [TAG_W-1:0] instr_tag_i,
  input  logic             exc_ack_i,
  input  logic             cnt_clr_i,
  output logic             exc_req_o,
  output logic [4:0]       exc_cause_o,
  output logic             stall_o,
  output logic [31:0]      viol_pc_o,
  output logic [4:0]       viol_cause_o,
  output logic [CNT_W-1:0] viol_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACKD
  } state_e;

  localparam logic [4:0] CAUSE_JALR = 5'd24;
  localparam logic [4:0] CAUSE_BRAN = 5'd25;
  localparam logic [4:0] CAUSE_LOAD = 5'd26;
  localparam logic [4:0] CAUSE_STOR = 5'd27;
  localparam logic [4:0] CAUSE_EXEC = 5'd28;

  state_e           state_q;
  logic             exc_req_q;
  logic             stall_q;
  logic [4:0]       exc_cause_q;
  logic [31:0]      viol_pc_q;
  logic [4:0]       viol_cause_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             class_en;
  logic             tainted;
  logic [4:0]       cause;
  logic             violation;
  logic             count_only;

  assign count_only = tccr_i[5];

  // Decode the check class: its enable bit, the taint condition and its cause.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    class_en = 1'b0;
    tainted  = 1'b0;
    cause    = 5'd0;
    unique case (chk_class_i)
      3'd1: begin
        class_en = tccr_i[0];
        tainted  = |operand_a_tag_i;
        cause    = CAUSE_JALR;
      end
      3'd2: begin
        class_en = tccr_i[1];
        tainted  = (|operand_a_tag_i) | (|operand_b_tag_i);
        cause    = CAUSE_BRAN;
      end
      3'd3: begin
        class_en = tccr_i[2];
        tainted  = |operand_a_tag_i;
        cause    = CAUSE_LOAD;
      end
      3'd4: begin
        class_en = tccr_i[3];
        tainted  = |operand_a_tag_i;
        cause    = CAUSE_STOR;
      end
      3'd5: begin
        class_en = tccr_i[4];
        tainted  = |instr_tag_i;
        cause    = CAUSE_EXEC;
      end
      default: begin
        class_en = 1'b0;
        tainted  = 1'b0;
        cause    = 5'd0;
      end
    endcase
  end

  // Checks run only in IDLE; a pending or just-acked request masks new ones.
  assign violation = check_valid_i && (state_q == ST_IDLE) && class_en && tainted;

  // The clear wins over a violation in the same cycle; otherwise count up and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (violation && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Request FSM with registered request, stall and cause outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      exc_req_q   <= 1'b0;
      stall_q     <= 1'b0;
      exc_cause_q <= 5'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (violation && !count_only) begin
            state_q     <= ST_REQ;
            exc_req_q   <= 1'b1;
            stall_q     <= 1'b1;
            exc_cause_q <= cause;
          end
        end
        ST_REQ: begin
          if (exc_ack_i) begin
            state_q   <= ST_ACKD;
            exc_req_q <= 1'b0;
            stall_q   <= 1'b0;
          end
        end
        ST_ACKD: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          exc_req_q <= 1'b0;
          stall_q   <= 1'b0;
        end
      endcase
    end
  end

  // Capture PC and cause of the most recent violation, whatever the mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      viol_pc_q    <= 32'd0;
      viol_cause_q <= 5'd0;
    end else if (violation) begin
      viol_pc_q    <= pc_i;
      viol_cause_q <= cause;
    end
  end

  // Saturating violation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign exc_req_o    = exc_req_q;
  assign stall_o      = stall_q;
  assign exc_cause_o  = exc_cause_q;
  assign viol_pc_o    = viol_pc_q;
  assign viol_cause_o = viol_cause_q;
  assign viol_cnt_o   = cnt_q;

endmodule
